frame_buffer_writer: RTL and testbench
======================================

FRAME_BUFFER_WRITER -- requirements
Module: frame_buffer_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, sample and RAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, RAM address width; FRAME_LEN = 2**(ADDR_WIDTH-1) words per bank.
REQ-003 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port s_data  in  DATA_WIDTH  incoming audio sample.
REQ-006 SHALL have port s_valid  in  1  s_data valid.
REQ-007 SHALL have port s_ready  out  1  writer accepts sample this cycle.
REQ-008 SHALL have port mem_data  out  DATA_WIDTH  to RAM port-A write data.
REQ-009 SHALL have port mem_addr  out  ADDR_WIDTH  to RAM port-A address, {bank, index}.
REQ-010 SHALL have port mem_we  out  1  to RAM port-A write enable.
REQ-011 SHALL have port frame_done  out  1  one-cycle pulse, a bank has just been filled.
REQ-012 SHALL have port frame_bank  out  1  bank of the most recent completed frame.
REQ-013 SHALL have port rd_release  in  1  consumer finished the oldest full bank (one-cycle pulse).
REQ-014 SHALL have port drop_cnt  out  8  saturating count of discarded samples.

Function
REQ-015 SHALL use RAM as ping-pong double buffer: bank 0 = lower half, bank 1 = upper half.
REQ-016 SHALL accept a sample on a cycle where s_valid and s_ready are both 1.
REQ-017 SHALL, one cycle after acceptance, drive mem_we=1, mem_addr={wr_bank, idx}, mem_data=accepted sample; mem_we=0 otherwise.
REQ-018 SHALL increment idx per accepted sample, wrapping FRAME_LEN-1 -> 0.
REQ-019 SHALL, on accepting the sample with idx=FRAME_LEN-1, set full[wr_bank], pulse frame_done in the same cycle as that last mem_we, and set frame_bank=wr_bank.
REQ-020 SHALL have states FILL (s_ready=1) and BLOCK (both banks full).
REQ-021 SHALL transition FILL->BLOCK on frame completion when the other bank is full; otherwise toggle wr_bank and stay in FILL.
REQ-022 SHALL, on rd_release, clear full[rd_bank] and toggle rd_bank; rd_release with no bank full SHALL be ignored.
REQ-023 SHALL transition BLOCK->FILL the cycle after rd_release, toggling wr_bank to the freed bank; idx restarts at 0.
REQ-024 SHALL apply rd_release before evaluating completion in the same cycle, so a simultaneous release and completion does not enter BLOCK.
REQ-025 SHALL keep drop_cnt at 255 once reached (no wrap).

Reset
REQ-026 SHALL, when rst_n=0, immediately force state=FILL, wr_bank=0, rd_bank=0, idx=0, full=00, mem_we=0, mem_addr=0, mem_data=0, frame_done=0, frame_bank=0, drop_cnt=0.
REQ-027 SHALL discard any partial frame on reset mid-operation; s_ready=0 during reset, 1 on the first clock after release.

Configuration
REQ-028 SHALL honour macro FBW_DROP_ON_FULL_EN: defined -> s_ready stays 1 in BLOCK, samples accepted in BLOCK are discarded (no mem_we) and drop_cnt increments.
REQ-029 SHALL, without FBW_DROP_ON_FULL_EN, drive s_ready=0 in BLOCK (backpressure) with drop_cnt tied to 0.

Structure
REQ-030 SHALL place the state enumeration (FILL, BLOCK) and the drop-counter width constant (8) in shared package fbw_pkg.
REQ-031 SHALL put full flags, rd_bank and release logic in one sub-module, fbw_bank_tracker.

Verification
REQ-032 SHALL test: with defaults, stream 32 samples 0x00..0x1F -> mem_addr 0..31, data matches, frame_done pulse with frame_bank=0.
REQ-033 SHALL test: 64 samples, no release -> second frame at addr 32..63, frame_bank=1, then BLOCK with s_ready=0 (macro off).
REQ-034 SHALL test: in BLOCK pulse rd_release -> next cycle FILL, next write to addr 0.
REQ-035 SHALL test: rd_release in the same cycle as the 64th acceptance -> no BLOCK, s_ready stays 1, writes continue at addr 0.
REQ-036 SHALL test (macro on): 300 samples offered in BLOCK -> no mem_we, drop_cnt=255.
REQ-037 SHALL test: rst_n low after 10 samples -> all outputs 0 asynchronously, next frame starts at addr 0.

Source files
------------

// File: rtl/fbw_pkg.sv
// Shared types and constants for the frame buffer writer.
package fbw_pkg;

   typedef enum logic [0:0] {
      ST_FILL  = 1'b0,
      ST_BLOCK = 1'b1
   } fbw_state_e;

   localparam int DROP_CNT_W = 8;

   function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
      if (v == {DROP_CNT_W{1'b1}}) begin
         return v;
      end else begin
         return v + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

endpackage

// File: rtl/fbw_bank_tracker.sv
// Tracks which ping-pong banks hold a complete frame and which one the consumer reads next.
module fbw_bank_tracker (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rd_release,
   input  logic       set_full,
   input  logic       set_bank,
   output logic [1:0] full_post_rel,
   output logic       rel_ok,
   output logic       rel_bank
);

   logic [1:0] full_r;
   logic [1:0] full_nxt_s;
   logic       rd_bank_r;
   logic       rel_ok_s;
   logic [1:0] post_rel_s;

   // Release is applied first so a completion in the same cycle sees the freed bank
   always_comb begin
      rel_ok_s   = rd_release & (full_r != 2'b00);
      post_rel_s = full_r;
      if (rel_ok_s) begin
         post_rel_s[rd_bank_r] = 1'b0;
      end else begin
         post_rel_s = full_r;
      end
      full_nxt_s = post_rel_s;
      if (set_full) begin
         full_nxt_s[set_bank] = 1'b1;
      end else begin
         full_nxt_s = post_rel_s;
      end
   end

   // Full flags and read-bank pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_r    <= 2'b00;
         rd_bank_r <= 1'b0;
      end else begin
         full_r    <= full_nxt_s;
         rd_bank_r <= rel_ok_s ? ~rd_bank_r : rd_bank_r;
      end
   end

   assign full_post_rel = post_rel_s;
   assign rel_ok        = rel_ok_s;
   assign rel_bank      = rd_bank_r;

endmodule

// File: rtl/frame_buffer_writer.sv
// Streams samples into a ping-pong RAM double buffer and flags completed frames.
// Build option FBW_DROP_ON_FULL_EN: keep accepting samples while both banks are full and discard them.
module frame_buffer_writer
   import fbw_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic                  frame_done,
   output logic                  frame_bank,
   input  logic                  rd_release,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   localparam int IDX_W = ADDR_WIDTH - 1;
   localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};
   localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

   fbw_state_e            state_r;
   fbw_state_e            state_nxt_s;
   logic                  wr_bank_r;
   logic                  wr_bank_nxt_s;
   logic [IDX_W-1:0]      idx_r;
   logic [IDX_W-1:0]      idx_nxt_s;

   logic                  ready_r;
   logic                  ready_nxt_s;
   logic                  mem_we_r;
   logic                  mem_we_nxt_s;
   logic [ADDR_WIDTH-1:0] mem_addr_r;
   logic [ADDR_WIDTH-1:0] mem_addr_nxt_s;
   logic [DATA_WIDTH-1:0] mem_data_r;
   logic [DATA_WIDTH-1:0] mem_data_nxt_s;
   logic                  frame_done_r;
   logic                  frame_done_nxt_s;
   logic                  frame_bank_r;
   logic                  frame_bank_nxt_s;

   logic                  accept_s;
   logic                  write_s;
   logic                  last_s;
   logic                  other_full_s;
   logic [1:0]            full_post_rel_s;
   logic                  rel_ok_s;
   logic                  rel_bank_s;

   assign accept_s     = s_valid & ready_r;
   assign write_s      = accept_s & (state_r == ST_FILL);
   assign last_s       = write_s & (idx_r == IDX_LAST);
   assign other_full_s = wr_bank_r ? full_post_rel_s[0] : full_post_rel_s[1];

   fbw_bank_tracker u_bank_tracker (
      .clk           (clk),
      .rst_n         (rst_n),
      .rd_release    (rd_release),
      .set_full      (last_s),
      .set_bank      (wr_bank_r),
      .full_post_rel (full_post_rel_s),
      .rel_ok        (rel_ok_s),
      .rel_bank      (rel_bank_s)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_FILL;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state: block only when the frame just finished and the other bank is still unread
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_FILL: begin
            if (last_s && other_full_s) begin
               state_nxt_s = ST_BLOCK;
            end else begin
               state_nxt_s = ST_FILL;
            end
         end
         ST_BLOCK: begin
            if (rel_ok_s) begin
               state_nxt_s = ST_FILL;
            end else begin
               state_nxt_s = ST_BLOCK;
            end
         end
         default: state_nxt_s = ST_FILL;
      endcase
   end

   // Write pointer: bank flips on completion, or jumps to the freed bank when leaving BLOCK
   always_comb begin
      wr_bank_nxt_s = wr_bank_r;
      idx_nxt_s     = idx_r;
      case (state_r)
         ST_FILL: begin
            if (write_s) begin
               idx_nxt_s = idx_r + IDX_ONE;
            end else begin
               idx_nxt_s = idx_r;
            end
            if (last_s && !other_full_s) begin
               wr_bank_nxt_s = ~wr_bank_r;
            end else begin
               wr_bank_nxt_s = wr_bank_r;
            end
         end
         ST_BLOCK: begin
            if (rel_ok_s) begin
               wr_bank_nxt_s = rel_bank_s;
               idx_nxt_s     = IDX_ZERO;
            end else begin
               wr_bank_nxt_s = wr_bank_r;
               idx_nxt_s     = idx_r;
            end
         end
         default: begin
            wr_bank_nxt_s = 1'b0;
            idx_nxt_s     = IDX_ZERO;
         end
      endcase
   end

   // Output decode, registered below
   always_comb begin
`ifdef FBW_DROP_ON_FULL_EN
      ready_nxt_s = 1'b1;
`else
      ready_nxt_s = (state_nxt_s == ST_FILL);
`endif
      mem_we_nxt_s     = write_s;
      frame_done_nxt_s = last_s;
      if (write_s) begin
         mem_addr_nxt_s = {wr_bank_r, idx_r};
         mem_data_nxt_s = s_data;
      end else begin
         mem_addr_nxt_s = mem_addr_r;
         mem_data_nxt_s = mem_data_r;
      end
      if (last_s) begin
         frame_bank_nxt_s = wr_bank_r;
      end else begin
         frame_bank_nxt_s = frame_bank_r;
      end
   end

   // Pointer and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_bank_r    <= 1'b0;
         idx_r        <= IDX_ZERO;
         ready_r      <= 1'b0;
         mem_we_r     <= 1'b0;
         mem_addr_r   <= {ADDR_WIDTH{1'b0}};
         mem_data_r   <= {DATA_WIDTH{1'b0}};
         frame_done_r <= 1'b0;
         frame_bank_r <= 1'b0;
      end else begin
         wr_bank_r    <= wr_bank_nxt_s;
         idx_r        <= idx_nxt_s;
         ready_r      <= ready_nxt_s;
         mem_we_r     <= mem_we_nxt_s;
         mem_addr_r   <= mem_addr_nxt_s;
         mem_data_r   <= mem_data_nxt_s;
         frame_done_r <= frame_done_nxt_s;
         frame_bank_r <= frame_bank_nxt_s;
      end
   end

`ifdef FBW_DROP_ON_FULL_EN
   logic [DROP_CNT_W-1:0] drop_cnt_r;

   // Saturating count of samples discarded while both banks are full
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_r <= {DROP_CNT_W{1'b0}};
      end else if (accept_s && (state_r == ST_BLOCK)) begin
         drop_cnt_r <= sat_inc(drop_cnt_r);
      end else begin
         drop_cnt_r <= drop_cnt_r;
      end
   end

   assign drop_cnt = drop_cnt_r;
`else
   assign drop_cnt = {DROP_CNT_W{1'b0}};
`endif

   assign s_ready    = ready_r;
   assign mem_we     = mem_we_r;
   assign mem_addr   = mem_addr_r;
   assign mem_data   = mem_data_r;
   assign frame_done = frame_done_r;
   assign frame_bank = frame_bank_r;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Randomized self-checking bench for frame_buffer_writer against a queue-based bank model.
module tb_frame_buffer_writer;

   localparam int DW = 8;
   localparam int AW = 6;
   localparam int FL = 32;
`ifdef FBW_DROP_ON_FULL_EN
   localparam bit DROP_MODE = 1'b1;
`else
   localparam bit DROP_MODE = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          s_valid = 1'b0;
   logic          rd_release = 1'b0;
   logic          s_ready;
   logic [DW-1:0] mem_data;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic          frame_done;
   logic          frame_bank;
   logic [7:0]    drop_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic          m_ready, m_we, m_done, m_fbank;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   int            m_drop, m_pos;
   bit            m_bank, m_blocked;
   bit            full_q[$];

   frame_buffer_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .mem_data(mem_data), .mem_addr(mem_addr), .mem_we(mem_we), .frame_done(frame_done),
      .frame_bank(frame_bank), .rd_release(rd_release), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_ready = 1'b0; m_we = 1'b0; m_done = 1'b0; m_fbank = 1'b0;
      m_addr = '0; m_data = '0; m_drop = 0; m_pos = 0;
      m_bank = 1'b0; m_blocked = 1'b0;
      full_q.delete();
   endtask

   // full banks form a FIFO; the consumer always releases the oldest one
   task automatic model_edge();
      bit acc, was_blk, rel_ok, freed;
      acc = s_valid && m_ready;
      was_blk = m_blocked;
      m_we = 1'b0; m_done = 1'b0; rel_ok = 1'b0; freed = 1'b0;
      if (rd_release && full_q.size() > 0) begin
         freed = full_q.pop_front();
         rel_ok = 1'b1;
      end
      if (acc && !was_blk) begin
         m_we = 1'b1;
         m_addr = AW'(int'(m_bank) * FL + m_pos);
         m_data = s_data;
         m_pos++;
         if (m_pos == FL) begin
            m_pos = 0; m_done = 1'b1; m_fbank = m_bank;
            full_q.push_back(m_bank);
            if (full_q.size() == 2) m_blocked = 1'b1;
            else m_bank = !m_bank;
         end
      end
      if (acc && was_blk && DROP_MODE && m_drop < 255) m_drop++;
      if (was_blk && rel_ok) begin
         m_blocked = 1'b0; m_bank = freed; m_pos = 0;
      end
      m_ready = DROP_MODE ? 1'b1 : !m_blocked;
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_edge();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [DW-1:0] d, input logic rel);
      s_valid = v; s_data = d; rd_release = rel;
      step();
   endtask

   task automatic apply_reset();
      s_valid = 1'b0; rd_release = 1'b0; rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      n_tests++;
      if ({s_ready, mem_we, mem_addr, mem_data, frame_done, frame_bank, drop_cnt} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got rdy=%b we=%b addr=%h data=%h done=%b bank=%b drop=%0d, required all 0",
                  s_ready, mem_we, mem_addr, mem_data, frame_done, frame_bank, drop_cnt);
      end
      rst_n = 1'b1;
      step();
      n_tests++;
      if (s_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready_after_release: got %b required 1", s_ready);
      end
   endtask

   task automatic test_first_frame();
      apply_reset();
      for (int i = 0; i < FL; i++) begin
         drive(1'b1, DW'(i), 1'b0);
         n_tests++;
         if (mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_data !== DW'(i) || frame_done !== (i == FL - 1)) begin
            n_fail++;
            $display("FAIL first_frame[%0d]: got we=%b addr=%0d data=%h done=%b required we=1 addr=%0d data=%h done=%b",
                     i, mem_we, mem_addr, mem_data, frame_done, i, i, (i == FL - 1));
         end
      end
      n_tests++;
      if (frame_bank !== 1'b0 || s_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL first_frame_bank: got bank=%b rdy=%b required bank=0 rdy=1", frame_bank, s_ready);
      end
      s_valid = 1'b0;
   endtask

   task automatic test_block();
      apply_reset();
      for (int i = 0; i < 2 * FL; i++) begin
         drive(1'b1, DW'($urandom), 1'b0);
         n_tests++;
         if ({s_ready, mem_we, frame_done} !== {m_ready, m_we, m_done} ||
             (m_we && {mem_addr, mem_data} !== {m_addr, m_data})) begin
            n_fail++;
            $display("FAIL block_stream[%0d]: got rdy/we/done=%b addr=%0d data=%h required %b addr=%0d data=%h",
                     i, {s_ready, mem_we, frame_done}, mem_addr, mem_data, {m_ready, m_we, m_done}, m_addr, m_data);
         end
      end
      n_tests++;
      if (mem_addr !== AW'(2 * FL - 1) || frame_done !== 1'b1 || frame_bank !== 1'b1) begin
         n_fail++;
         $display("FAIL block_second_frame: got addr=%0d done=%b bank=%b required addr=63 done=1 bank=1",
                  mem_addr, frame_done, frame_bank);
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, DW'($urandom), 1'b0);
         n_tests++;
         if (mem_we !== 1'b0 || s_ready !== DROP_MODE || drop_cnt !== 8'(m_drop)) begin
            n_fail++;
            $display("FAIL block_hold[%0d]: got we=%b rdy=%b drop=%0d required we=0 rdy=%b drop=%0d",
                     i, mem_we, s_ready, drop_cnt, DROP_MODE, m_drop);
         end
      end
   endtask

   task automatic test_release();
      drive(1'b0, '0, 1'b1);
      rd_release = 1'b0;
      n_tests++;
      if (s_ready !== 1'b1 || mem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL release_ready: got rdy=%b we=%b required rdy=1 we=0", s_ready, mem_we);
      end
      drive(1'b1, DW'($urandom), 1'b0);
      n_tests++;
      if (mem_we !== 1'b1 || mem_addr !== AW'(0) || mem_data !== m_data) begin
         n_fail++;
         $display("FAIL release_first_write: got we=%b addr=%0d data=%h required we=1 addr=0 data=%h",
                  mem_we, mem_addr, mem_data, m_data);
      end
      s_valid = 1'b0;
   endtask

   task automatic test_simultaneous();
      apply_reset();
      for (int i = 0; i < 2 * FL + 40; i++) begin
         drive(1'b1, DW'($urandom), (i == 2 * FL - 1));
         n_tests++;
         if ({s_ready, mem_we, frame_done} !== {m_ready, m_we, m_done} ||
             (m_we && {mem_addr, mem_data} !== {m_addr, m_data})) begin
            n_fail++;
            $display("FAIL simul_stream[%0d]: got rdy/we/done=%b addr=%0d data=%h required %b addr=%0d data=%h",
                     i, {s_ready, mem_we, frame_done}, mem_addr, mem_data, {m_ready, m_we, m_done}, m_addr, m_data);
         end
         if (i == 2 * FL - 1) begin
            n_tests++;
            if (s_ready !== 1'b1 || frame_done !== 1'b1 || frame_bank !== 1'b1) begin
               n_fail++;
               $display("FAIL simul_no_block: got rdy=%b done=%b bank=%b required 1 1 1", s_ready, frame_done, frame_bank);
            end
         end
         if (i == 2 * FL) begin
            n_tests++;
            if (mem_we !== 1'b1 || mem_addr !== AW'(0)) begin
               n_fail++;
               $display("FAIL simul_next_addr: got we=%b addr=%0d required we=1 addr=0", mem_we, mem_addr);
            end
         end
      end
      rd_release = 1'b0;
      s_valid = 1'b0;
   endtask

   task automatic test_drop();
      int we_seen;
      apply_reset();
      for (int i = 0; i < 2 * FL; i++) drive(1'b1, DW'($urandom), 1'b0);
      we_seen = 0;
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, DW'($urandom), 1'b0);
         if (mem_we !== 1'b0) we_seen++;
      end
      n_tests++;
      if (we_seen != 0) begin
         n_fail++;
         $display("FAIL drop_no_write: got %0d write cycles required 0", we_seen);
      end
      n_tests++;
      if (drop_cnt !== (DROP_MODE ? 8'd255 : 8'd0) || s_ready !== DROP_MODE) begin
         n_fail++;
         $display("FAIL drop_count: got drop=%0d rdy=%b required drop=%0d rdy=%b",
                  drop_cnt, s_ready, (DROP_MODE ? 255 : 0), DROP_MODE);
      end
      s_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      for (int i = 0; i < 10; i++) drive(1'b1, DW'($urandom_range(1, 255)), 1'b0);
      s_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      n_tests++;
      if ({s_ready, mem_we, mem_addr, mem_data, frame_done, frame_bank, drop_cnt} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_async: got rdy=%b we=%b addr=%h data=%h done=%b bank=%b drop=%0d, required all 0",
                  s_ready, mem_we, mem_addr, mem_data, frame_done, frame_bank, drop_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      for (int i = 0; i < FL; i++) begin
         drive(1'b1, DW'($urandom), 1'b0);
         n_tests++;
         if (mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_data !== m_data || frame_done !== (i == FL - 1)) begin
            n_fail++;
            $display("FAIL reset_mid_frame[%0d]: got we=%b addr=%0d data=%h done=%b required we=1 addr=%0d data=%h done=%b",
                     i, mem_we, mem_addr, mem_data, frame_done, i, m_data, (i == FL - 1));
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 3) != 0), DW'($urandom), ($urandom_range(0, 15) == 0));
         n_tests++;
         if ({s_ready, mem_we, frame_done} !== {m_ready, m_we, m_done} ||
             (m_we && {mem_addr, mem_data} !== {m_addr, m_data}) ||
             (m_done && frame_bank !== m_fbank) || drop_cnt !== 8'(m_drop)) begin
            n_fail++;
            $display("FAIL random[%0d]: got rdy/we/done=%b addr=%0d data=%h bank=%b drop=%0d required %b addr=%0d data=%h bank=%b drop=%0d",
                     i, {s_ready, mem_we, frame_done}, mem_addr, mem_data, frame_bank, drop_cnt,
                     {m_ready, m_we, m_done}, m_addr, m_data, m_fbank, m_drop);
         end
      end
      s_valid = 1'b0;
      rd_release = 1'b0;
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_block();
      test_release();
      test_simultaneous();
      test_drop();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
